bola_colisao: RTL and testbench
===============================

# bola_colisao

Ball-motion and collision stage of the Breakout datapath. Moves the ball one pixel per axis on each game tick and bounces it off walls, the paddle and the block grid. Keeps the block bitmap and produces the `hit_block` and `endgame_ball` event pulses consumed by the scoreboard (`placar`). Ball position and bitmap go to the renderer.

## Interface
- `H_RES`, 640, screen width in pixels
- `V_RES`, 480, screen height in pixels
- `BALL`, 8, ball side in pixels (square)
- `PAD_W`, 64, paddle width
- `PAD_Y`, 440, paddle top row
- `COLS`, 10, block columns; block width is 64 px, so `COLS*64 = H_RES`
- `ROWS`, 4, block rows; block height is 16 px
- `BLK_TOP`, 32, first row of the block grid
- `SERVE_X`, 316, serve x position (ball top-left corner)
- `SERVE_Y`, 300, serve y position (ball top-left corner)
- `TICK_DIV`, 416667, clock cycles per movement tick

- `clock`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low; clears all state
- `start`  in  1  level; game enabled (same signal the scoreboard uses)
- `paddle_x`  in  10  paddle left edge, sampled on tick cycles
- `ball_x`  out  10  ball top-left x
- `ball_y`  out  10  ball top-left y
- `blocos`  out  ROWS*COLS  block present bitmap; bit index is `row*COLS+col`
- `hit_block`  out  1  one-cycle pulse per destroyed block
- `endgame_ball`  out  1  one-cycle pulse when the ball leaves the bottom edge
- `venceu`  out  1  high while all blocks are cleared

## Operation
- Reset values:
  - `ball_x=SERVE_X`, `ball_y=SERVE_Y`
  - `dx=+1`, `dy=-1` (up)
  - `blocos` all ones
  - `hit_block=0`, `endgame_ball=0`, `venceu=0`
  - state ESPERA, tick counter 0
- Tick counter:
  - Free-running, counts 0..TICK_DIV-1.
  - `tick` is high in the cycle the count equals TICK_DIV-1; the counter then wraps to 0.
- States:
  - ESPERA: ball held at the serve position, `dx=+1`, `dy=-1`. Goes to JOGANDO when `start=1`.
  - JOGANDO: on `tick && start`, performs one movement step. `start=0` freezes the ball and keeps the state.
  - PERDEU: entered on a bottom miss. Goes to ESPERA when `start=0`. This forces the start release the scoreboard waits for.
  - VENCEU: entered when `blocos==0`. Ball frozen, `venceu=1`. Left only by reset.
- Movement step. Compute next position `nx=x+dx`, `ny=y+dy` in 11-bit signed arithmetic, with no wrap.
- x-axis handling, independent of the y-axis:
  - If `nx<0` or `nx+BALL>H_RES`: negate `dx`, x unchanged.
  - Otherwise x takes `nx`.
- y-axis handling, first match wins:
  1. Block hit: center `cx=nx+BALL/2`, `cy=ny+BALL/2` lies in the grid (`BLK_TOP<=cy<BLK_TOP+ROWS*16`). Index = `((cy-BLK_TOP)>>4)*COLS + (cx>>6)`. If that bit is set: clear it, negate `dy`, y unchanged, pulse `hit_block`.
  2. Paddle: `dy=+1`, `ny+BALL==PAD_Y`, and `paddle_x<=cx<paddle_x+PAD_W`. Set `dy=-1`, y unchanged.
  3. Top: `ny<0`. Set `dy=+1`, y unchanged.
  4. Bottom: `ny+BALL>V_RES`. Pulse `endgame_ball`, go to PERDEU. Ball position and direction reload to serve values.
  5. Otherwise y takes `ny`.
- At most one block is destroyed per tick.
- After a block clear leaves `blocos==0`, the next cycle enters VENCEU.
- `hit_block` and `endgame_ball` are never high together. Both are only produced while `start=1`, so the scoreboard always samples them.

## Timing
- Movement latency: ball outputs change on the clock edge that ends the tick cycle, then hold for TICK_DIV cycles.
- Event pulses are registered:
  - `hit_block` and `endgame_ball` are high for exactly the one cycle following the tick edge that detected the event.
  - The `blocos` bit clears on that same edge.
- ESPERA→JOGANDO: one cycle after `start` is sampled high. The first step happens on the next tick.
- PERDEU→ESPERA: one cycle after `start` is sampled low.
- Reset mid-operation: all outputs go to reset values immediately (asynchronously). An in-flight pulse is dropped.
- `paddle_x` is used only in tick cycles. No synchronization is done here.

## Test plan
All scenarios use TICK_DIV=2.
- Reset then `start=1`:
  - Required: ball at (316,300) with `blocos` all ones.
  - After 2 ticks: (318,298).
  - `hit_block` and `endgame_ball` stay low.
- Left wall: force the ball near x=1 moving `dx=-1`.
  - Required: x sequence 1,0,0,1; `dx` flips at the tick where `nx=-1`.
- Block: ball rising under block row 3, column 5.
  - Required: exactly one `hit_block` pulse.
  - Bit 35 of `blocos` clears.
  - `dy` becomes +1.
  - Re-entering the cleared cell gives no pulse.
- Paddle: hold `paddle_x=288` and let the ball fall with `cx=320`.
  - Required: the ball reverses at `y=PAD_Y-BALL=432`, with no `endgame_ball`.
- Miss: hold `paddle_x=0` and let the ball fall with `cx=320`.
  - Required: one `endgame_ball` pulse and state PERDEU, ball at serve position.
  - Ball stays frozen while `start=1`.
  - `start=0` then `start=1` resumes play.
- Clear all blocks except one, then hit it.
  - Required: `hit_block` pulse, `blocos==0`, `venceu=1` on the next cycle, ball frozen.
  - Assert `reset` low mid-pulse: all outputs at reset values immediately.

Source files
------------

// File: rtl/bola_colisao.sv
// Breakout ball motion and collision stage: moves the ball once per tick, bounces it off
// walls, paddle and block grid, and keeps the block bitmap plus the hit/miss event pulses.
module bola_colisao #(
    parameter int unsigned H_RES    = 640,
    parameter int unsigned V_RES    = 480,
    parameter int unsigned BALL     = 8,
    parameter int unsigned PAD_W    = 64,
    parameter int unsigned PAD_Y    = 440,
    parameter int unsigned COLS     = 10,
    parameter int unsigned ROWS     = 4,
    parameter int unsigned BLK_TOP  = 32,
    parameter int unsigned SERVE_X  = 316,
    parameter int unsigned SERVE_Y  = 300,
    parameter int unsigned TICK_DIV = 416667
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [9:0]           paddle_x,
    output logic [9:0]           ball_x,
    output logic [9:0]           ball_y,
    output logic [ROWS*COLS-1:0] blocos,
    output logic                 hit_block,
    output logic                 endgame_ball,
    output logic                 venceu
);

    localparam int unsigned NB = ROWS * COLS;
    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SW = 12;

    localparam logic signed [SW-1:0] S_ONE  = SW'(1);
    localparam logic signed [SW-1:0] S_HALF = SW'(BALL / 2);
    localparam logic signed [SW-1:0] S_BALL = SW'(BALL);
    localparam logic signed [SW-1:0] S_HRES = SW'(H_RES);
    localparam logic signed [SW-1:0] S_VRES = SW'(V_RES);
    localparam logic signed [SW-1:0] S_PADW = SW'(PAD_W);
    localparam logic signed [SW-1:0] S_PADY = SW'(PAD_Y);
    localparam logic signed [SW-1:0] S_COLS = SW'(COLS);
    localparam logic signed [SW-1:0] S_BTOP = SW'(BLK_TOP);
    localparam logic signed [SW-1:0] S_BBOT = SW'(BLK_TOP + ROWS * 16);

    typedef enum logic [1:0] {ESPERA, JOGANDO, PERDEU, VENCEU} state_t;

    state_t            state, state_nxt;
    logic              dx_pos, dy_pos, dx_nxt, dy_nxt;
    logic [9:0]        x_nxt, y_nxt;
    logic [NB-1:0]     blocos_nxt, blk_mask;
    logic              hit_nxt, end_nxt;
    logic [CW-1:0]     cnt;
    logic              tick;

    logic signed [SW-1:0] nx, ny, cx, cy, px, blk_idx;
    logic                 x_bounce, in_grid, blk_hit, pad_hit, top_hit, bot_hit;

    // Free-running movement tick divider
    assign tick = (cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)    cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + CW'(1);
    end

    // Candidate next position and the collision tests against it
    always_comb begin
        nx       = $signed({2'b00, ball_x}) + (dx_pos ? S_ONE : -S_ONE);
        ny       = $signed({2'b00, ball_y}) + (dy_pos ? S_ONE : -S_ONE);
        cx       = nx + S_HALF;
        cy       = ny + S_HALF;
        px       = $signed({2'b00, paddle_x});
        x_bounce = nx[SW-1] || (nx + S_BALL > S_HRES);
        in_grid  = (cy >= S_BTOP) && (cy < S_BBOT);
        blk_idx  = ((cy - S_BTOP) >>> 4) * S_COLS + (cx >>> 6);
        pad_hit  = dy_pos && (ny + S_BALL == S_PADY) && (px <= cx) && (cx < px + S_PADW);
        top_hit  = ny[SW-1];
        bot_hit  = (ny + S_BALL > S_VRES);
    end

    // One-hot select of the grid cell under the ball centre
    always_comb begin
        blk_mask = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            if (in_grid && (blk_idx == $signed(SW'(i)))) blk_mask[i] = 1'b1;
        end
    end

    assign blk_hit = |(blocos & blk_mask);

    always_comb begin
        state_nxt  = state;
        x_nxt      = ball_x;
        y_nxt      = ball_y;
        dx_nxt     = dx_pos;
        dy_nxt     = dy_pos;
        blocos_nxt = blocos;
        hit_nxt    = 1'b0;
        end_nxt    = 1'b0;
        case (state)
            ESPERA: begin
                x_nxt  = 10'(SERVE_X);
                y_nxt  = 10'(SERVE_Y);
                dx_nxt = 1'b1;
                dy_nxt = 1'b0;
                if (start) state_nxt = JOGANDO;
            end
            JOGANDO: begin
                if (blocos == '0) begin
                    state_nxt = VENCEU;
                end else if (tick && start) begin
                    if (x_bounce) dx_nxt = !dx_pos;
                    else          x_nxt  = nx[9:0];
                    // y-axis priority: block, paddle, top wall, bottom miss, free move
                    if (blk_hit) begin
                        blocos_nxt = blocos & ~blk_mask;
                        dy_nxt     = !dy_pos;
                        hit_nxt    = 1'b1;
                    end else if (pad_hit) begin
                        dy_nxt = 1'b0;
                    end else if (top_hit) begin
                        dy_nxt = 1'b1;
                    end else if (bot_hit) begin
                        end_nxt   = 1'b1;
                        state_nxt = PERDEU;
                        x_nxt     = 10'(SERVE_X);
                        y_nxt     = 10'(SERVE_Y);
                        dx_nxt    = 1'b1;
                        dy_nxt    = 1'b0;
                    end else begin
                        y_nxt = ny[9:0];
                    end
                end
            end
            PERDEU: begin
                if (!start) state_nxt = ESPERA;
            end
            VENCEU: begin
                state_nxt = VENCEU;
            end
            default: state_nxt = ESPERA;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= ESPERA;
            ball_x       <= 10'(SERVE_X);
            ball_y       <= 10'(SERVE_Y);
            dx_pos       <= 1'b1;
            dy_pos       <= 1'b0;
            blocos       <= '1;
            hit_block    <= 1'b0;
            endgame_ball <= 1'b0;
            venceu       <= 1'b0;
        end else begin
            state        <= state_nxt;
            ball_x       <= x_nxt;
            ball_y       <= y_nxt;
            dx_pos       <= dx_nxt;
            dy_pos       <= dy_nxt;
            blocos       <= blocos_nxt;
            hit_block    <= hit_nxt;
            endgame_ball <= end_nxt;
            venceu       <= (state_nxt == VENCEU);
        end
    end

endmodule

// File: tb/tb_bola_colisao.sv
// Bench for bola_colisao: full-size game checked every cycle against a behavioural model,
// plus a one-block instance for the win and asynchronous-reset scenarios.
module tb_bola_colisao;

    localparam int TD = 2;
    localparam int NB = 40;
    localparam int WAIT_M = 0, PLAY_M = 1, LOST_M = 2, WON_M = 3;

    logic          clk, rst_n, start;
    logic [9:0]    paddle_x;
    logic [9:0]    ball_x, ball_y;
    logic [NB-1:0] blocos;
    logic          hit_block, endgame_ball, venceu;

    logic          rst2_n, start2;
    logic [9:0]    ball2_x, ball2_y;
    logic [0:0]    blocos2;
    logic          hit2, end2, venceu2;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 0;

    bola_colisao #(.TICK_DIV(TD)) dut (
        .clock(clk), .reset(rst_n), .start(start), .paddle_x(paddle_x),
        .ball_x(ball_x), .ball_y(ball_y), .blocos(blocos),
        .hit_block(hit_block), .endgame_ball(endgame_ball), .venceu(venceu)
    );

    bola_colisao #(
        .H_RES(64), .V_RES(64), .PAD_Y(56), .COLS(1), .ROWS(1), .BLK_TOP(8),
        .SERVE_X(20), .SERVE_Y(40), .TICK_DIV(TD)
    ) dut2 (
        .clock(clk), .reset(rst2_n), .start(start2), .paddle_x(10'd0),
        .ball_x(ball2_x), .ball_y(ball2_y), .blocos(blocos2),
        .hit_block(hit2), .endgame_ball(end2), .venceu(venceu2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural game model for the full-size instance
    int            m_x, m_y, m_dx, m_dy, m_mode, m_cyc, m_steps, first_hit;
    logic [NB-1:0] m_blk;
    bit            m_hit, m_end, m_won;
    int            step_x [4096];
    int            step_y [4096];

    always @(posedge clk or negedge rst_n) begin : model
        int x, y, dx, dy, mode, nx, ny, cx, cy, idx, s, px;
        logic [NB-1:0] blk;
        bit hit, eg, tk, bh;
        if (!rst_n) begin
            m_x <= 316; m_y <= 300; m_dx <= 1; m_dy <= -1;
            m_mode <= WAIT_M; m_cyc <= 0; m_steps <= 0; first_hit <= 0;
            m_blk <= '1; m_hit <= 0; m_end <= 0; m_won <= 0;
        end else begin
            x = m_x; y = m_y; dx = m_dx; dy = m_dy; mode = m_mode; blk = m_blk;
            s = m_steps; hit = 0; eg = 0;
            px = int'(paddle_x);
            tk = (m_cyc % TD) == TD - 1;
            case (mode)
                WAIT_M: begin
                    x = 316; y = 300; dx = 1; dy = -1;
                    if (start) mode = PLAY_M;
                end
                PLAY_M: begin
                    if (blk == '0) begin
                        mode = WON_M;
                    end else if (tk && start) begin
                        nx = x + dx; ny = y + dy; cx = nx + 4; cy = ny + 4;
                        if (nx < 0 || nx + 8 > 640) dx = -dx; else x = nx;
                        bh = 0; idx = 0;
                        if (cy >= 32 && cy < 96) begin
                            idx = ((cy - 32) / 16) * 10 + cx / 64;
                            bh  = blk[idx];
                        end
                        if (bh) begin
                            blk[idx] = 1'b0; dy = -dy; hit = 1;
                        end else if (dy == 1 && ny + 8 == 440 && px <= cx && cx < px + 64) begin
                            dy = -1;
                        end else if (ny < 0) begin
                            dy = 1;
                        end else if (ny + 8 > 480) begin
                            eg = 1; mode = LOST_M; x = 316; y = 300; dx = 1; dy = -1;
                        end else begin
                            y = ny;
                        end
                        s = s + 1;
                        if (s < 4096) begin
                            step_x[s] <= x;
                            step_y[s] <= y;
                        end
                        if (hit && first_hit == 0) first_hit <= s;
                    end
                end
                LOST_M: if (!start) mode = WAIT_M;
                default: ;
            endcase
            m_x <= x; m_y <= y; m_dx <= dx; m_dy <= dy; m_mode <= mode; m_blk <= blk;
            m_steps <= s; m_cyc <= m_cyc + 1;
            m_hit <= hit; m_end <= eg; m_won <= (mode == WON_M);
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            check("ball_x", ball_x, m_x);
            check("ball_y", ball_y, m_y);
            check("blocos", longint'(blocos), longint'(m_blk));
            check("hit_block", hit_block, m_hit);
            check("endgame_ball", endgame_ball, m_end);
            check("venceu", venceu, m_won);
            check("pulse_overlap", hit_block && endgame_ball, 0);
        end
    end

    function automatic logic [9:0] track(input int x);
        int p;
        p = x + 4 - 32;
        if (p < 0) p = 0;
        return 10'(p);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        rst_n = 0; start = 0; paddle_x = 0; rst2_n = 0; start2 = 0;
        repeat (3) @(negedge clk);
        check("rst_ball_x", ball_x, 316);
        check("rst_ball_y", ball_y, 300);
        check("rst_blocos", longint'(blocos), 64'hFF_FFFF_FFFF);
        check("rst_hit", hit_block, 0);
        check("rst_end", endgame_ball, 0);
        check("rst_venceu", venceu, 0);

        rst_n = 1; cmp_en = 1;
        repeat (2) @(negedge clk);
        start = 1;
        repeat (4) @(negedge clk);
        check("two_steps_x", ball_x, 318);
        check("two_steps_y", ball_y, 298);

        // Paddle follows the ball: no misses, blocks get hit, walls get bounced
        repeat (2400) begin
            paddle_x = track(m_x);
            @(negedge clk);
        end
        check("pin_step2_x", step_x[2], 318);
        check("pin_first_hit_step", first_hit, 209);
        check("pin_hit_pos_x", step_x[209], 525);
        check("pin_hit_pos_y", step_y[209], 92);
        check("pin_paddle_y", step_y[549], 431);
        check("pin_paddle_x", step_x[549], 400);
        check("pin_after_paddle_y", step_y[550], 430);
        check("pin_wall_x948", step_x[948], 1);
        check("pin_wall_x949", step_x[949], 0);
        check("pin_wall_x950", step_x[950], 0);
        check("pin_wall_x951", step_x[951], 1);

        // Paddle kept away from the ball until it leaves the bottom edge
        got = 0;
        for (int i = 0; i < 4000; i++) begin
            paddle_x = (m_x + 4 < 320) ? 10'd576 : 10'd0;
            @(negedge clk);
            if (endgame_ball) begin got = 1; break; end
        end
        check("miss_seen", got, 1);
        check("miss_serve_x", ball_x, 316);
        check("miss_serve_y", ball_y, 300);
        check("miss_state_lost", m_mode, LOST_M);
        repeat (20) @(negedge clk);
        check("lost_frozen_x", ball_x, 316);
        check("lost_frozen_y", ball_y, 300);
        start = 0;
        repeat (2) @(negedge clk);
        start = 1;
        repeat (10) @(negedge clk);
        check("resume_moves", ball_x > 316, 1);
        cmp_en = 0;

        // One-block instance: the only block is hit at step 21 from (20,40)
        @(negedge clk);
        rst2_n = 1; start2 = 1;
        check("w_rst_blocos", blocos2, 1);
        got = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (hit2) begin got = 1; break; end
        end
        check("w_hit_seen", got, 1);
        check("w_hit_x", ball2_x, 41);
        check("w_hit_y", ball2_y, 20);
        check("w_hit_blocos", blocos2, 0);
        check("w_hit_venceu", venceu2, 0);
        @(negedge clk);
        check("w_venceu", venceu2, 1);
        check("w_single_pulse", hit2, 0);
        repeat (10) @(negedge clk);
        check("w_frozen_x", ball2_x, 41);
        check("w_frozen_y", ball2_y, 20);
        check("w_venceu_hold", venceu2, 1);
        rst2_n = 0; #1;
        check("w_rst_x", ball2_x, 20);
        check("w_rst_y", ball2_y, 40);
        check("w_rst_venceu", venceu2, 0);

        // Reset asserted while the hit pulse is high
        @(negedge clk);
        rst2_n = 1;
        got = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (hit2) begin got = 1; break; end
        end
        check("r_hit_seen", got, 1);
        rst2_n = 0; #1;
        check("r_hit_dropped", hit2, 0);
        check("r_end", end2, 0);
        check("r_x", ball2_x, 20);
        check("r_y", ball2_y, 40);
        check("r_blocos", blocos2, 1);
        check("r_venceu", venceu2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
